// File: rtl/pe_pkg.sv
// Shared constants and types for the MMM processing-element register file.
package pe_pkg;

    localparam int unsigned PE_WIDTH = 16;
    localparam int unsigned PE_DEPTH = 8;

    localparam logic WMODE_LOAD = 1'b0;
    localparam logic WMODE_ACC  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/pe_clear_seq.sv
// Bulk-clear sequencer: walks every entry once, one per cycle, after a clear request.
module pe_clear_seq
    import pe_pkg::*;
#(
    parameter  int unsigned DEPTH = PE_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    r_state;
    clr_state_e    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_busy;

    // State register; busy is re-registered from the next state so it tracks CLEAR exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == ST_CLEAR);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        clr_en   = (r_state == ST_CLEAR);
        clr_addr = r_cnt;
    end

    assign busy = r_busy;

endmodule

// File: rtl/pe_reg_file.sv
// DEPTH x WIDTH register file with load/accumulate write port, two bypassed
// registered read ports and a bulk-clear sequencer.
module pe_reg_file
    import pe_pkg::*;
#(
    parameter  int unsigned WIDTH = PE_WIDTH,
    parameter  int unsigned DEPTH = PE_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             wmode,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             acc_ovf
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_acc_ovf;

    logic             w_busy;
    logic             w_clr_en;
    logic [AW-1:0]    w_clr_addr;
    logic             w_wa_ok;
    logic             w_ra_ok;
    logic             w_rb_ok;
    logic [WIDTH-1:0] w_old;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_wdata_new;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    pe_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (w_busy),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr)
    );

    // Addresses past the last entry only exist when DEPTH is not a power of two.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign w_wa_ok = 1'b1;
        assign w_ra_ok = 1'b1;
        assign w_rb_ok = 1'b1;
    end else begin : g_npow2
        assign w_wa_ok = ({1'b0, waddr}   < (AW+1)'(DEPTH));
        assign w_ra_ok = ({1'b0, raddr_a} < (AW+1)'(DEPTH));
        assign w_rb_ok = ({1'b0, raddr_b} < (AW+1)'(DEPTH));
    end

    assign w_old              = w_wa_ok ? r_mem[waddr] : '0;
    assign {w_carry, w_sum}   = (WIDTH+1)'(w_old) + (WIDTH+1)'(wdata);
    assign w_wdata_new        = (wmode == WMODE_LOAD) ? wdata : w_sum;
    assign w_wr_en            = we & w_wa_ok & ~w_clr_en;

    // Storage: clear sequencer owns the write port while it runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[waddr] <= w_wdata_new;
        end
    end

    // Read bypass: a same-cycle clear or write to the read address wins over stored contents.
    always_comb begin
        w_rd_a = '0;
        if (!w_ra_ok) begin
            w_rd_a = '0;
        end else if (w_clr_en && (raddr_a == w_clr_addr)) begin
            w_rd_a = '0;
        end else if (w_wr_en && (raddr_a == waddr)) begin
            w_rd_a = w_wdata_new;
        end else begin
            w_rd_a = r_mem[raddr_a];
        end
    end

    always_comb begin
        w_rd_b = '0;
        if (!w_rb_ok) begin
            w_rd_b = '0;
        end else if (w_clr_en && (raddr_b == w_clr_addr)) begin
            w_rd_b = '0;
        end else if (w_wr_en && (raddr_b == waddr)) begin
            w_rd_b = w_wdata_new;
        end else begin
            w_rd_b = r_mem[raddr_b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_acc_ovf <= 1'b0;
        end else begin
            if (re_a) begin
                r_rdata_a <= w_rd_a;
            end
            if (re_b) begin
                r_rdata_b <= w_rd_b;
            end
            r_acc_ovf <= w_wr_en & (wmode == WMODE_ACC) & w_carry;
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign acc_ovf = r_acc_ovf;
    assign busy    = w_busy;

endmodule

// File: tb/tb_pe_reg_file.sv
// Scoreboard bench for pe_reg_file: directed cycles push hand-computed expectations,
// a monitor pops and compares whenever the DUT presents read data or status.
module tb_pe_reg_file;

    localparam logic LD = 1'b0;
    localparam logic AC = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, wmode;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata;
    logic        re_a, re_b, clr_req;
    logic [15:0] rdata_a, rdata_b;
    logic        busy, acc_ovf;

    typedef struct packed {
        logic busy;
        logic ovf;
    } st_t;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    st_t         qs[$];
    logic        drv_on;
    logic        a_pend, b_pend, s_pend;
    logic [15:0] last_a, last_b;
    int          checks = 0;
    int          errors = 0;

    pe_reg_file #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .busy(busy), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which cycles carry something for the monitor to check.
    always @(posedge clk) begin
        a_pend <= re_a & ~reset;
        b_pend <= re_b & ~reset;
        s_pend <= drv_on & ~reset;
    end

    always @(negedge clk) begin
        if (reset) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (a_pend) begin
                if (qa.size() == 0) begin
                    chk("qa_underflow", 16'd1, 16'd0);
                end else begin
                    last_a = qa.pop_front();
                    chk("rdata_a", rdata_a, last_a);
                end
            end else if (s_pend) begin
                chk("hold_a", rdata_a, last_a);
            end
            if (b_pend) begin
                if (qb.size() == 0) begin
                    chk("qb_underflow", 16'd1, 16'd0);
                end else begin
                    last_b = qb.pop_front();
                    chk("rdata_b", rdata_b, last_b);
                end
            end else if (s_pend) begin
                chk("hold_b", rdata_b, last_b);
            end
            if (s_pend) begin
                if (qs.size() == 0) begin
                    chk("qs_underflow", 16'd1, 16'd0);
                end else begin
                    st_t s;
                    s = qs.pop_front();
                    chk("busy", 16'(busy), 16'(s.busy));
                    chk("acc_ovf", 16'(acc_ovf), 16'(s.ovf));
                end
            end
        end
    end

    task automatic idle_inputs();
        we = 0; wmode = LD; waddr = 0; wdata = 0;
        re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0; clr_req = 0;
    endtask

    // One driven cycle with the expected outcome after its rising edge.
    task automatic cyc(input logic w, input logic wm, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ra_en, input logic [2:0] ra, input logic [15:0] ea,
                       input logic rb_en, input logic [2:0] rb, input logic [15:0] eb,
                       input logic clr, input logic e_busy, input logic e_ovf);
        @(negedge clk);
        we = w; wmode = wm; waddr = wa; wdata = wd;
        re_a = ra_en; raddr_a = ra; re_b = rb_en; raddr_b = rb; clr_req = clr;
        drv_on = 1'b1;
        if (ra_en) qa.push_back(ea);
        if (rb_en) qb.push_back(eb);
        qs.push_back({e_busy, e_ovf});
    endtask

    // Caller has already set the inputs at a falling edge; reset lands before the next rising edge.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_rdata_a"}, rdata_a, 16'h0000);
        chk({tag, "_rdata_b"}, rdata_b, 16'h0000);
        chk({tag, "_busy"}, 16'(busy), 16'h0000);
        chk({tag, "_acc_ovf"}, 16'(acc_ovf), 16'h0000);
        idle_inputs();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1;
        drv_on = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Reset state visible on both ports.
        for (int i = 0; i < 8; i++)
            cyc(0, LD, 0, 0, 1, 3'(i), 16'h0000, 1, 3'(7 - i), 16'h0000, 0, 0, 0);

        // Simple load, read one cycle later, hold with re low, no-op write cycle.
        cyc(1, LD, 3, 16'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, LD, 0, 0, 1, 3, 16'd5, 0, 0, 0, 0, 0, 0);
        cyc(0, LD, 3, 16'd99, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, LD, 0, 0, 1, 3, 16'd5, 1, 3, 16'd5, 0, 0, 0);

        // Write-to-read bypass on both ports.
        cyc(1, LD, 2, 16'd235, 1, 2, 16'd235, 1, 2, 16'd235, 0, 0, 0);

        // Accumulate wrap with carry pulse, then no carry; bypass returns the sum.
        cyc(1, LD, 1, 16'hFFF0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, AC, 1, 16'h0020, 1, 1, 16'h0010, 0, 0, 0, 0, 0, 1);
        cyc(1, AC, 1, 16'h0008, 0, 0, 0, 1, 1, 16'h0018, 0, 0, 0);
        cyc(0, LD, 0, 0, 1, 1, 16'h0018, 0, 0, 0, 0, 0, 0);
        cyc(1, LD, 5, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, AC, 5, 16'h8000, 1, 5, 16'h0000, 0, 0, 0, 0, 0, 1);
        cyc(1, AC, 5, 16'h0003, 0, 0, 0, 1, 5, 16'h0003, 0, 0, 0);
        cyc(1, LD, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fill, then bulk clear with writes, accumulates and a second request during busy.
        for (int i = 0; i < 8; i++)
            cyc(1, LD, 3'(i), 16'h1000 + 16'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, LD, 0, 0, 1, 0, 16'h1000, 1, 7, 16'h1007, 0, 0, 0);
        cyc(1, LD, 6, 16'h0777, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            logic eb;
            eb = (j < 8);
            case (j)
                1: cyc(1, LD, 7, 16'hBEEF, 1, 0, 16'h0000, 1, 6, 16'h0777, 0, eb, 0);
                2: cyc(1, AC, 7, 16'hFFFF, 1, 1, 16'h0000, 1, 5, 16'h1005, 0, eb, 0);
                3: cyc(0, LD, 0, 0, 1, 7, 16'h1007, 1, 1, 16'h0000, 1, eb, 0);
                8: cyc(0, LD, 0, 0, 1, 7, 16'h0000, 1, 6, 16'h0000, 0, eb, 0);
                default: cyc(0, LD, 0, 0, 1, 3'(j - 1), 16'h0000, 1, 7, 16'h1007, 0, eb, 0);
            endcase
        end
        cyc(0, LD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, LD, 0, 0, 1, 3'(i), 16'h0000, 1, 3'(7 - i), 16'h0000, 0, 0, 0);

        // Reset while clearing, right after an overflowing accumulate.
        cyc(1, LD, 2, 16'hFFFF, 1, 2, 16'hFFFF, 0, 0, 0, 0, 0, 0);
        cyc(1, AC, 2, 16'h0001, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        idle_inputs();
        drv_on = 1'b0;
        pulse_reset("rst_clear");
        cyc(1, LD, 3, 16'h0033, 1, 3, 16'h0033, 1, 2, 16'h0000, 0, 0, 0);
        cyc(0, LD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while an accumulate is being presented.
        cyc(1, LD, 4, 16'd100, 1, 4, 16'd100, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        we = 1; wmode = AC; waddr = 4; wdata = 16'd5; re_a = 1; raddr_a = 4;
        drv_on = 1'b0;
        pulse_reset("rst_acc");
        cyc(0, LD, 0, 0, 1, 4, 16'h0000, 1, 3, 16'h0000, 0, 0, 0);

        @(negedge clk);
        idle_inputs();
        drv_on = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("qa_drained", 16'(qa.size()), 16'h0000);
        chk("qb_drained", 16'(qb.size()), 16'h0000);
        chk("qs_drained", 16'(qs.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
